// File: rtl/uart_frame_parser.sv
// uart_frame_parser: delineates SYNC/LEN/PAYLOAD/CSUM frames from the UART
// receiver byte stream, buffers the payload, verifies the 8-bit checksum and
// streams the payload out on a valid/ready byte interface.
// Optional build macro: FRAME_TIMEOUT_EN (inter-byte timeout inside a frame).
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_SYNC    | hunting for SYNC_BYTE, other bytes silently dropped
// S_LEN     | next byte is the payload length
// S_PAYLOAD | storing payload bytes into the buffer
// S_CSUM    | next byte is the checksum of LEN + payload
// S_OUT     | streaming the buffered payload to the consumer
module uart_frame_parser #(
  parameter int          MAX_PAYLOAD  = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 8700
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic [7:0] o_Data,
  output logic       o_Data_Valid,
  input  logic       i_Data_Ready,
  output logic       o_Data_Last,
  output logic [7:0] o_Frame_Len,
  output logic       o_Frame_Done,
  output logic       o_Frame_Err,
  output logic       o_Overrun
);

  localparam logic [2:0] S_SYNC    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CSUM    = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  localparam int         AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  // Elaboration-time parameter sanity checks
  if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255) begin : g_bad_max_payload
    $error("MAX_PAYLOAD must be in 1..255");
  end
  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must be at least 2");
  end

  logic [2:0] state_q;
  logic [7:0] len_q;
  logic [7:0] idx_q;
  logic [7:0] sum_q;
  logic       frame_err_q;
  logic       overrun_q;
  logic       frame_done_q;
  logic [7:0] mem [MAX_PAYLOAD];

  logic       out_valid;
  logic       is_last;
  logic       xfer;
  logic       timeout;

  assign out_valid = (state_q == S_OUT);
  assign is_last   = (idx_q == (len_q - 8'd1));
  assign xfer      = out_valid && i_Data_Ready;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  logic [TW-1:0] timer_q;
  logic          in_frame;

  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign timeout  = in_frame && !i_Rx_DV && (timer_q == TW'(TIMEOUT_CLKS - 1));

  // Idle-clock counter inside a frame; held at 0 outside, so entry starts at 0
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      timer_q <= '0;
    end else if (!in_frame || i_Rx_DV) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Payload buffer write; contents are don't-care after reset so no reset here
  always_ff @(posedge i_Clock) begin
    if (!i_Reset && (state_q == S_PAYLOAD) && i_Rx_DV) begin
      mem[idx_q[AW-1:0]] <= i_Rx_Byte;
    end
  end

  // Frame FSM with registered one-cycle status pulses
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= S_SYNC;
      len_q        <= 8'd0;
      idx_q        <= 8'd0;
      sum_q        <= 8'd0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_SYNC: begin
          if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
            state_q <= S_LEN;
          end
        end
        S_LEN: begin
          if (timeout) begin
            frame_err_q <= 1'b1;
            state_q     <= S_SYNC;
          end else if (i_Rx_DV) begin
            // SYNC_BYTE here is just a length value; no resync
            if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN)) begin
              frame_err_q <= 1'b1;
              state_q     <= S_SYNC;
            end else begin
              len_q   <= i_Rx_Byte;
              sum_q   <= i_Rx_Byte;
              idx_q   <= 8'd0;
              state_q <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (timeout) begin
            frame_err_q <= 1'b1;
            state_q     <= S_SYNC;
          end else if (i_Rx_DV) begin
            sum_q <= sum_q + i_Rx_Byte;
            idx_q <= idx_q + 8'd1;
            if (is_last) begin
              state_q <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (timeout) begin
            frame_err_q <= 1'b1;
            state_q     <= S_SYNC;
          end else if (i_Rx_DV) begin
            if (i_Rx_Byte == sum_q) begin
              idx_q   <= 8'd0;
              state_q <= S_OUT;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_SYNC;
            end
          end
        end
        S_OUT: begin
          // Incoming bytes cannot be buffered while draining, including on the
          // final transfer cycle
          if (i_Rx_DV) begin
            overrun_q <= 1'b1;
          end
          if (xfer) begin
            if (is_last) begin
              frame_done_q <= 1'b1;
              state_q      <= S_SYNC;
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= S_SYNC;
        end
      endcase
    end
  end

  assign o_Data_Valid = out_valid;
  assign o_Data       = out_valid ? mem[idx_q[AW-1:0]] : 8'd0;
  assign o_Data_Last  = out_valid && is_last;
  assign o_Frame_Len  = len_q;
  assign o_Frame_Done = frame_done_q;
  assign o_Frame_Err  = frame_err_q;
  assign o_Overrun    = overrun_q;

endmodule
